// File: rtl/router_pkg.sv
// Shared definitions for the 1xN router: check-mode selectors, header field
// layout and the router FSM state names.
package router_pkg;

  localparam int CHK_XOR = 0;
  localparam int CHK_SUM = 1;

  // Address sits in the low bits of the header byte; length sits directly above it.
  localparam int HDR_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } router_state_e;

endpackage

// File: rtl/router_chk_accum.sv
// Running packet check: XOR parity or additive checksum, seeded by the header
// and stepped once per accepted payload byte.
module router_chk_accum
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHK_MODE   = CHK_XOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  seed,
  input  logic                  accum,
  input  logic [DATA_WIDTH-1:0] byte_in,
  output logic [DATA_WIDTH-1:0] chk
);

  logic [DATA_WIDTH-1:0] chk_step;

  assign chk_step = (CHK_MODE == CHK_SUM) ? (chk + byte_in) : (chk ^ byte_in);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       chk <= '0;
    else if (clear) chk <= '0;
    else if (seed)  chk <= byte_in;
    else if (accum) chk <= chk_step;
  end

endmodule

// File: rtl/router_pkt_register.sv
// Packet register between the router input pins and the per-port FIFOs:
// latches the header, forwards/holds payload and checks the packet at its parity byte.
module router_pkt_register
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_PORTS  = 3,
  parameter int CHK_MODE   = CHK_XOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  parity_err,
  output logic                  len_err,
  output logic                  addr_err,
  output logic                  err
);

  localparam int LEN_WIDTH = DATA_WIDTH - ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PORT_LIMIT = (ADDR_WIDTH + 1)'(NUM_PORTS);

  logic [DATA_WIDTH-1:0] hdr_q, hold_q, chk_q, chk_byte;
  logic [LEN_WIDTH-1:0]  cnt_q, hdr_len;
  logic addr_ok, hdr_accept, hdr_reject, pay_take, chk_fire;
  logic parity_done_d, parity_err_d, len_err_d;

  assign addr_ok    = {1'b0, d_in[HDR_ADDR_LSB +: ADDR_WIDTH]} < PORT_LIMIT;
  assign hdr_accept = detect_add && pkt_valid && addr_ok;
  assign hdr_reject = detect_add && pkt_valid && !addr_ok;
  assign hdr_len    = hdr_q[HDR_ADDR_LSB + ADDR_WIDTH +: LEN_WIDTH];
  assign pay_take   = ld_state && pkt_valid && !full_state;

  // The parity byte is judged either straight off the pins or, if it was parked, from the hold register.
  assign chk_fire = !full_state &&
                    ((ld_state && !pkt_valid && !fifo_full) ||
                     (laf_state && low_pkt_valid && !parity_done));
  assign chk_byte = laf_state ? hold_q : d_in;

  router_chk_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .CHK_MODE  (CHK_MODE)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .clear  (1'b0),
    .seed   (hdr_accept),
    .accum  (pay_take),
    .byte_in(d_in),
    .chk    (chk_q)
  );

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    parity_done_d = parity_done;
    parity_err_d  = parity_err;
    len_err_d     = len_err;
    if (hdr_accept) begin
      parity_done_d = 1'b0;
      parity_err_d  = 1'b0;
      len_err_d     = 1'b0;
    end
    if (chk_fire) begin
      parity_done_d = 1'b1;
      parity_err_d  = (chk_q != chk_byte);
      len_err_d     = (cnt_q != hdr_len);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_q         <= '0;
      hold_q        <= '0;
      cnt_q         <= '0;
      dout          <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      parity_err    <= 1'b0;
      len_err       <= 1'b0;
      addr_err      <= 1'b0;
      err           <= 1'b0;
    end else begin
      addr_err    <= hdr_reject;
      parity_done <= parity_done_d;
      parity_err  <= parity_err_d;
      len_err     <= len_err_d;
      err         <= parity_err_d | len_err_d;

      if (hdr_accept) begin
        hdr_q <= d_in;
        cnt_q <= '0;
      end else if (pay_take && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (rst_int_reg)               low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid) low_pkt_valid <= 1'b1;

      if (!full_state) begin
        if (lfd_state)                  dout <= hdr_q;
        else if (ld_state && !fifo_full) dout <= d_in;
        else if (laf_state)             dout <= hold_q;
        if (ld_state && fifo_full) hold_q <= d_in;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_register.sv
// Self-checking bench for router_pkt_register: XOR and checksum instances driven
// by an FSM-like packet sequencer, compared against a packet-level reference model.
module tb_router_pkt_register;

  logic       clk, rst, pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg;
  logic [7:0] d_in, dout, s_dout;
  logic       parity_done, low_pkt_valid, parity_err, len_err, addr_err, err;
  logic       s_parity_done, s_low_pkt_valid, s_parity_err, s_len_err, s_addr_err, s_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] pay [128];
  bit         full_at [129];
  logic [7:0] dout_log [$];
  logic [7:0] frozen_log [$];
  bit         obs_early;

  router_pkt_register #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_PORTS(3), .CHK_MODE(0)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .d_in(d_in), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .parity_err(parity_err), .len_err(len_err), .addr_err(addr_err), .err(err)
  );

  router_pkt_register #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_PORTS(3), .CHK_MODE(1)) dut_sum (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .d_in(d_in), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(s_dout), .parity_done(s_parity_done), .low_pkt_valid(s_low_pkt_valid),
    .parity_err(s_parity_err), .len_err(s_len_err), .addr_err(s_addr_err), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: whole-packet check value and length verdict.
  function automatic logic [7:0] model_chk(input bit sum_mode, input logic [7:0] hdr, input int n);
    int acc;
    acc = int'(hdr);
    for (int i = 0; i < n; i++)
      acc = sum_mode ? (acc + int'(pay[i])) % 256 : (acc ^ int'(pay[i]));
    return 8'(acc);
  endfunction

  function automatic bit model_len_err(input logic [7:0] hdr, input int n);
    int cnt;
    cnt = (n > 63) ? 63 : n;
    return cnt != int'(hdr >> 2);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0;
    ld_state = 0; laf_state = 0; full_state = 0; rst_int_reg = 0;
  endtask

  task automatic clear_full();
    for (int i = 0; i < 129; i++) full_at[i] = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
  endtask

  // Sequences one packet like the router FSM would; only records observations.
  task automatic send_packet(input logic [7:0] hdr, input int n, input logic [7:0] par);
    dout_log.delete(); frozen_log.delete(); obs_early = 1'b0;
    idle_ctl(); detect_add = 1; pkt_valid = 1; d_in = hdr; cyc();
    detect_add = 0; lfd_state = 1; d_in = (n > 0) ? pay[0] : par; cyc();
    dout_log.push_back(dout); obs_early |= parity_done;
    lfd_state = 0;
    for (int i = 0; i < n; i++) begin
      ld_state = 1; pkt_valid = 1; d_in = pay[i]; fifo_full = full_at[i]; cyc();
      if (full_at[i]) begin
        frozen_log.push_back(dout);
        ld_state = 0; full_state = 1; d_in = 8'($urandom); cyc();
        frozen_log.push_back(dout);
        full_state = 0; fifo_full = 0; laf_state = 1; cyc();
        laf_state = 0;
      end
      dout_log.push_back(dout); obs_early |= parity_done;
    end
    ld_state = 1; pkt_valid = 0; d_in = par; fifo_full = full_at[n]; cyc();
    if (full_at[n]) begin
      obs_early |= parity_done;
      ld_state = 0; full_state = 1; d_in = 8'($urandom); cyc();
      obs_early |= parity_done;
      full_state = 0; fifo_full = 0; laf_state = 1; cyc();
    end
    idle_ctl();
  endtask

  task automatic finish_packet();
    idle_ctl(); rst_int_reg = 1; cyc(); rst_int_reg = 0;
  endtask

  task automatic test_reset();
    idle_ctl(); d_in = 8'hFF; rst = 0;
    repeat (2) cyc();
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++;
    if ({parity_done, low_pkt_valid, parity_err, len_err, addr_err, err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
        {parity_done, low_pkt_valid, parity_err, len_err, addr_err, err});
    end
    checks++;
    if ({s_dout, s_parity_done, s_low_pkt_valid, s_parity_err, s_len_err, s_addr_err, s_err} !== 14'b0) begin
      errors++; $display("FAIL reset_sum_dut: got %h want 0",
        {s_dout, s_parity_done, s_low_pkt_valid, s_parity_err, s_len_err, s_addr_err, s_err});
    end
    rst = 1; cyc();
    checks++;
    if ({dout, parity_done, err} !== 10'b0) begin
      errors++; $display("FAIL reset_release: got %h want 0", {dout, parity_done, err});
    end
  endtask

  task automatic test_xor_good();
    clear_full(); fill_random(5);
    send_packet(8'h15, 5, model_chk(0, 8'h15, 5));
    checks++;
    if (dout_log.size() != 6) begin errors++; $display("FAIL good_dout_len: got %0d want 6", dout_log.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (dout_log[i] !== ((i == 0) ? 8'h15 : pay[i-1])) begin
        errors++; $display("FAIL good_dout[%0d]: got %h want %h", i, dout_log[i], (i == 0) ? 8'h15 : pay[i-1]);
      end
    end
    checks++;
    if ({parity_done, parity_err, len_err, err, low_pkt_valid} !== 5'b10001) begin
      errors++; $display("FAIL good_flags: got %b want 10001", {parity_done, parity_err, len_err, err, low_pkt_valid});
    end
    checks++;
    if (obs_early !== 1'b0) begin errors++; $display("FAIL good_early_done: got %b want 0", obs_early); end
    finish_packet();
    checks++;
    if ({low_pkt_valid, parity_done} !== 2'b01) begin
      errors++; $display("FAIL good_rst_int: got %b want 01", {low_pkt_valid, parity_done});
    end
  endtask

  task automatic test_bad_parity();
    clear_full();
    if (model_chk(0, 8'h15, 5) == 8'd48) pay[0] = pay[0] ^ 8'h01;
    send_packet(8'h15, 5, 8'd48);
    checks++;
    if ({parity_done, parity_err, len_err, err} !== 4'b1101) begin
      errors++; $display("FAIL bad_parity: got %b want 1101", {parity_done, parity_err, len_err, err});
    end
    finish_packet();
  endtask

  task automatic test_addr_err();
    logic [7:0] prev;
    prev = dout;
    idle_ctl(); detect_add = 1; pkt_valid = 1; d_in = 8'h17; cyc();
    checks++;
    if ({addr_err, dout} !== {1'b1, prev}) begin
      errors++; $display("FAIL addr_err_pulse: got %b/%h want 1/%h", addr_err, dout, prev);
    end
    checks++;
    if (parity_err !== 1'b1) begin errors++; $display("FAIL addr_no_clear: got %b want 1", parity_err); end
    idle_ctl(); cyc();
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_width: got %b want 0", addr_err); end
    lfd_state = 1; cyc(); idle_ctl();
    checks++;
    if (dout !== 8'h15) begin errors++; $display("FAIL addr_no_latch: got %h want 15", dout); end
  endtask

  task automatic test_len_mismatch();
    clear_full(); fill_random(8);
    send_packet(8'h15, 8, model_chk(0, 8'h15, 8));
    checks++;
    if ({parity_done, parity_err, len_err, err} !== 4'b1011) begin
      errors++; $display("FAIL len_mismatch: got %b want 1011", {parity_done, parity_err, len_err, err});
    end
    finish_packet();
  endtask

  task automatic test_fifo_full();
    clear_full(); fill_random(5); pay[2] = 8'hA5; full_at[2] = 1;
    send_packet(8'h15, 5, model_chk(0, 8'h15, 5));
    checks++;
    if (frozen_log.size() != 2 || frozen_log[0] !== pay[1] || frozen_log[1] !== pay[1]) begin
      errors++; $display("FAIL full_freeze: got %0d entries, first %h want %h", frozen_log.size(),
        (frozen_log.size() > 0) ? frozen_log[0] : 8'hxx, pay[1]);
    end
    checks++;
    if (dout_log.size() != 6 || dout_log[3] !== 8'hA5) begin
      errors++; $display("FAIL full_laf_dout: got %h want a5", (dout_log.size() > 3) ? dout_log[3] : 8'hxx);
    end
    checks++;
    if ({parity_done, parity_err, len_err, err} !== 4'b1000) begin
      errors++; $display("FAIL full_count_once: got %b want 1000", {parity_done, parity_err, len_err, err});
    end
    finish_packet();
  endtask

  task automatic test_parity_full();
    clear_full(); fill_random(3); full_at[3] = 1;
    send_packet(8'h0D, 3, model_chk(0, 8'h0D, 3));
    checks++;
    if (obs_early !== 1'b0) begin errors++; $display("FAIL parfull_early: got %b want 0", obs_early); end
    checks++;
    if ({parity_done, parity_err, len_err, err, low_pkt_valid} !== 5'b10001) begin
      errors++; $display("FAIL parfull_flags: got %b want 10001", {parity_done, parity_err, len_err, err, low_pkt_valid});
    end
    finish_packet();
  endtask

  task automatic test_zero_len();
    clear_full();
    send_packet(8'h02, 0, 8'h02);
    checks++;
    if ({parity_done, parity_err, len_err, err} !== 4'b1000) begin
      errors++; $display("FAIL zero_len: got %b want 1000", {parity_done, parity_err, len_err, err});
    end
    finish_packet();
  endtask

  task automatic test_saturate();
    clear_full(); fill_random(66);
    send_packet(8'hFD, 66, model_chk(0, 8'hFD, 66));
    checks++;
    if ({parity_done, parity_err, len_err, err} !== 4'b1000) begin
      errors++; $display("FAIL len_saturate: got %b want 1000", {parity_done, parity_err, len_err, err});
    end
    finish_packet();
  endtask

  task automatic test_sum();
    clear_full(); pay[0] = 8'hF0; pay[1] = 8'h20;
    send_packet(8'h09, 2, 8'h19);
    checks++;
    if ({s_parity_done, s_parity_err, s_len_err, s_err} !== 4'b1000) begin
      errors++; $display("FAIL sum_good: got %b want 1000", {s_parity_done, s_parity_err, s_len_err, s_err});
    end
    finish_packet();
    send_packet(8'h09, 2, 8'h1A);
    checks++;
    if ({s_parity_done, s_parity_err, s_len_err, s_err} !== 4'b1101) begin
      errors++; $display("FAIL sum_bad: got %b want 1101", {s_parity_done, s_parity_err, s_len_err, s_err});
    end
    finish_packet();
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      int len, n, v, bad;
      logic [7:0] hdr, par;
      bit pe, le, spe;
      len = $urandom_range(0, 12);
      hdr = 8'((len << 2) | $urandom_range(0, 2));
      v = $urandom_range(0, 4);
      n = (v == 0) ? len + 1 : ((v == 1 && len > 0) ? len - 1 : len);
      fill_random(n); clear_full();
      for (int i = 0; i <= n; i++) full_at[i] = ($urandom_range(0, 5) == 0);
      par = model_chk(0, hdr, n);
      if ($urandom_range(0, 2) == 0) par = par ^ 8'(1 << $urandom_range(0, 7));
      pe = model_chk(0, hdr, n) != par;
      spe = model_chk(1, hdr, n) != par;
      le = model_len_err(hdr, n);
      send_packet(hdr, n, par);
      checks++;
      if ({parity_done, parity_err, len_err, err} !== {1'b1, pe, le, pe | le}) begin
        errors++; $display("FAIL rand_xor[%0d]: got %b want %b", k,
          {parity_done, parity_err, len_err, err}, {1'b1, pe, le, pe | le});
      end
      checks++;
      if ({s_parity_done, s_parity_err, s_len_err, s_err} !== {1'b1, spe, le, spe | le}) begin
        errors++; $display("FAIL rand_sum[%0d]: got %b want %b", k,
          {s_parity_done, s_parity_err, s_len_err, s_err}, {1'b1, spe, le, spe | le});
      end
      bad = (dout_log.size() != n + 1) ? 1 : 0;
      for (int i = 0; i < dout_log.size() && i <= n; i++)
        if (dout_log[i] !== ((i == 0) ? hdr : pay[i-1])) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_dout[%0d]: got %0d wrong bytes want 0", k, bad); end
      checks++;
      if (obs_early !== 1'b0) begin errors++; $display("FAIL rand_early[%0d]: got 1 want 0", k); end
      finish_packet();
    end
  endtask

  task automatic test_rst_int_detect();
    clear_full(); fill_random(2);
    send_packet(8'h0A, 2, model_chk(0, 8'h0A, 2));
    checks++;
    if (low_pkt_valid !== 1'b1) begin errors++; $display("FAIL both_pre: got %b want 1", low_pkt_valid); end
    detect_add = 1; pkt_valid = 1; d_in = 8'h06; rst_int_reg = 1; cyc();
    idle_ctl();
    checks++;
    if ({low_pkt_valid, parity_done} !== 2'b00) begin
      errors++; $display("FAIL both_effect: got %b want 00", {low_pkt_valid, parity_done});
    end
    lfd_state = 1; cyc(); idle_ctl();
    checks++;
    if (dout !== 8'h06) begin errors++; $display("FAIL both_hdr: got %h want 06", dout); end
  endtask

  task automatic test_mid_reset();
    idle_ctl(); detect_add = 1; pkt_valid = 1; d_in = 8'h15; cyc();
    detect_add = 0; lfd_state = 1; d_in = 8'h5A; cyc();
    lfd_state = 0; ld_state = 1; cyc();
    d_in = 8'hC3; cyc();
    rst = 0; #1;
    checks++;
    if ({dout, parity_done, low_pkt_valid, parity_err, len_err, addr_err, err} !== 14'b0) begin
      errors++; $display("FAIL mid_reset: got %h want 0",
        {dout, parity_done, low_pkt_valid, parity_err, len_err, addr_err, err});
    end
    idle_ctl(); #2; rst = 1; cyc();
    lfd_state = 1; cyc(); idle_ctl();
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_hdr_cleared: got %h want 00", dout); end
    clear_full(); fill_random(5);
    send_packet(8'h15, 5, model_chk(0, 8'h15, 5));
    checks++;
    if ({parity_done, err, dout_log[0]} !== {2'b10, 8'h15}) begin
      errors++; $display("FAIL post_reset_pkt: got %b/%h want 10/15", {parity_done, err}, dout_log[0]);
    end
    finish_packet();
  endtask

  initial begin
    rst = 1; d_in = '0; idle_ctl();
    test_reset();
    test_xor_good();
    test_bad_parity();
    test_addr_err();
    test_len_mismatch();
    test_fifo_full();
    test_parity_full();
    test_zero_len();
    test_saturate();
    test_sum();
    test_random();
    test_rst_int_detect();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
